l1i_miss_handler: RTL

Miss-sequencing controller for the L1 instruction cache. Captures cache-miss reports, queues them in a small deduplicating FIFO, and issues one line-refill request at a time to the next memory level over a valid/ready handshake. On each response it drives the cache's update port for one cycle and tells fetch where to resume. It holds fetch stalled while any miss is outstanding.

---
 rtl/l1i_miss_handler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/l1i_miss_handler.sv
// L1 instruction-cache miss sequencer: merges duplicate miss reports into a small
// in-order queue and refills one line at a time from the next memory level.
module l1i_miss_handler #(
  parameter int fetchingAddressWidth    = 64,
  parameter int cacheLineWith           = 512,
  parameter int offsetWidth             = 6,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int missQueueDepth          = 4
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               cacheMiss_i,
  input  logic [fetchingAddressWidth-1:0]    missedAddress_i,
  input  logic [instructionCounterWidth-1:0] missedInstMajorId_i,
  input  logic [PidSize-1:0]                 missedPid_i,
  input  logic [TidSize-1:0]                 missedTid_i,
  output logic                               memRequest_o,
  output logic [fetchingAddressWidth-1:0]    memRequestAddress_o,
  output logic [PidSize-1:0]                 memRequestPid_o,
  output logic [TidSize-1:0]                 memRequestTid_o,
  input  logic                               memRequestReady_i,
  input  logic                               memResponse_i,
  input  logic [cacheLineWith-1:0]           memResponseLine_i,
  output logic                               cacheUpdate_o,
  output logic [fetchingAddressWidth-1:0]    cacheUpdateAddress_o,
  output logic [cacheLineWith-1:0]           cacheUpdateLine_o,
  output logic [PidSize-1:0]                 cacheUpdatePid_o,
  output logic [TidSize-1:0]                 cacheUpdateTid_o,
  output logic                               resumeFetch_o,
  output logic [fetchingAddressWidth-1:0]    resumeAddress_o,
  output logic [instructionCounterWidth-1:0] resumeInstMajorId_o,
  output logic                               fetchStall_o,
  output logic                               missDropped_o
);

  localparam int ptr_width   = $clog2(missQueueDepth);
  localparam int count_width = ptr_width + 1;

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RESP, UPDATE} state_t;

  function automatic logic [fetchingAddressWidth-1:0] line_of(
    input logic [fetchingAddressWidth-1:0] addr);
    return {addr[fetchingAddressWidth-1:offsetWidth], {offsetWidth{1'b0}}};
  endfunction

  state_t                             state;
  logic [ptr_width-1:0]               head_ptr;
  logic [ptr_width-1:0]               tail_ptr;
  logic [count_width-1:0]             entry_count;

  logic [fetchingAddressWidth-1:0]    queue_addr  [missQueueDepth];
  logic [instructionCounterWidth-1:0] queue_major [missQueueDepth];
  logic [PidSize-1:0]                 queue_pid   [missQueueDepth];
  logic [TidSize-1:0]                 queue_tid   [missQueueDepth];

  logic [fetchingAddressWidth-1:0]    inflight_addr;
  logic [instructionCounterWidth-1:0] inflight_major;
  logic [PidSize-1:0]                 inflight_pid;
  logic [TidSize-1:0]                 inflight_tid;

  logic [missQueueDepth-1:0]          slot_valid;
  logic [fetchingAddressWidth-1:0]    miss_line;
  logic                               dup_hit;
  logic                               queue_full;
  logic                               enq;
  logic                               drop;
  logic                               pop;

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < missQueueDepth; i++) begin
      slot_valid[i] = {1'b0, ptr_width'(i) - head_ptr} < entry_count;
    end
  end

  always_comb begin
    miss_line = line_of(missedAddress_i);
    dup_hit   = 1'b0;
    for (int i = 0; i < missQueueDepth; i++) begin
      if (slot_valid[i] && line_of(queue_addr[i]) == miss_line &&
          queue_pid[i] == missedPid_i && queue_tid[i] == missedTid_i)
        dup_hit = 1'b1;
    end
    if (state != IDLE && line_of(inflight_addr) == miss_line &&
        inflight_pid == missedPid_i && inflight_tid == missedTid_i)
      dup_hit = 1'b1;
    queue_full = entry_count == count_width'(missQueueDepth);
    enq        = cacheMiss_i && !queue_full && !dup_hit;
    drop       = cacheMiss_i && queue_full && !dup_hit;
    pop        = (entry_count != '0) && (state == IDLE || state == UPDATE);
  end

  // Storage needs no reset: liveness is decided purely by the pointers and count.
  always_ff @(posedge clock_i) begin
    if (enq) begin
      queue_addr[tail_ptr]  <= missedAddress_i;
      queue_major[tail_ptr] <= missedInstMajorId_i;
      queue_pid[tail_ptr]   <= missedPid_i;
      queue_tid[tail_ptr]   <= missedTid_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state                <= IDLE;
      head_ptr             <= '0;
      tail_ptr             <= '0;
      entry_count          <= '0;
      inflight_addr        <= '0;
      inflight_major       <= '0;
      inflight_pid         <= '0;
      inflight_tid         <= '0;
      memRequest_o         <= 1'b0;
      cacheUpdate_o        <= 1'b0;
      resumeFetch_o        <= 1'b0;
      missDropped_o        <= 1'b0;
      cacheUpdateAddress_o <= '0;
      cacheUpdateLine_o    <= '0;
      cacheUpdatePid_o     <= '0;
      cacheUpdateTid_o     <= '0;
      resumeAddress_o      <= '0;
      resumeInstMajorId_o  <= '0;
    end else begin
      missDropped_o <= drop;
      cacheUpdate_o <= 1'b0;
      resumeFetch_o <= 1'b0;
      entry_count   <= entry_count + count_width'(enq) - count_width'(pop);
      if (enq)
        tail_ptr <= tail_ptr + ptr_width'(1);
      if (pop) begin
        head_ptr       <= head_ptr + ptr_width'(1);
        inflight_addr  <= queue_addr[head_ptr];
        inflight_major <= queue_major[head_ptr];
        inflight_pid   <= queue_pid[head_ptr];
        inflight_tid   <= queue_tid[head_ptr];
      end
      case (state)
        IDLE: begin
          if (pop) begin
            state        <= REQUEST;
            memRequest_o <= 1'b1;
          end
        end
        REQUEST: begin
          if (memRequestReady_i) begin
            state        <= WAIT_RESP;
            memRequest_o <= 1'b0;
          end
        end
        // Update-side outputs get their own copy so the next pop cannot disturb them.
        WAIT_RESP: begin
          if (memResponse_i) begin
            state                <= UPDATE;
            cacheUpdate_o        <= 1'b1;
            resumeFetch_o        <= 1'b1;
            cacheUpdateLine_o    <= memResponseLine_i;
            cacheUpdateAddress_o <= line_of(inflight_addr);
            cacheUpdatePid_o     <= inflight_pid;
            cacheUpdateTid_o     <= inflight_tid;
            resumeAddress_o      <= inflight_addr;
            resumeInstMajorId_o  <= inflight_major;
          end
        end
        UPDATE: begin
          if (pop) begin
            state        <= REQUEST;
            memRequest_o <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign memRequestAddress_o = line_of(inflight_addr);
  assign memRequestPid_o     = inflight_pid;
  assign memRequestTid_o     = inflight_tid;
  assign fetchStall_o        = (entry_count != '0) || (state != IDLE);

endmodule
